// File: rtl/arm_wb_pkg.sv
// -----------------------------------------------------------------------------
// arm_wb_pkg
// Shared types and constants for the ARM write-back stage.
//   WB_DEPTH_DEFAULT : default number of write-back queue entries
//   REG_IDX_W        : register-file index width
//   WB_DATA_W        : canonical result width of the 32-bit ARM datapath
//   wb_entry_t       : one queued register-file write {wb_en, dest, data}
// -----------------------------------------------------------------------------
package arm_wb_pkg;

  localparam int WB_DEPTH_DEFAULT = 2;
  localparam int REG_IDX_W        = 4;
  localparam int WB_DATA_W        = 32;

  // Canonical queue entry. The stage builds an identically shaped entry sized
  // by its own DATA_W parameter and hands it to the queue as a type parameter.
  typedef struct packed {
    logic                 wb_en;
    logic [REG_IDX_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : arm_wb_pkg

// File: rtl/arm_wb_if.sv
// -----------------------------------------------------------------------------
// arm_wb_if
// MEM -> WB handshake bundle carrying one completed instruction.
//   mem_valid     : MEM stage presents an instruction
//   mem_ready     : write-back queue can accept this cycle
//   wb_en_in      : instruction writes a register
//   mem_r_en_in   : instruction is a load (select mem_data_in)
//   dest_in       : destination register index
//   alu_result_in : ALU result
//   mem_data_in   : load data
// Modports: master = MEM stage (producer), slave = write-back stage.
// -----------------------------------------------------------------------------
interface arm_wb_if
  import arm_wb_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                 mem_valid;
  logic                 mem_ready;
  logic                 wb_en_in;
  logic                 mem_r_en_in;
  logic [REG_IDX_W-1:0] dest_in;
  logic [DATA_W-1:0]    alu_result_in;
  logic [DATA_W-1:0]    mem_data_in;

  modport master (
    output mem_valid, wb_en_in, mem_r_en_in, dest_in, alu_result_in, mem_data_in,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, wb_en_in, mem_r_en_in, dest_in, alu_result_in, mem_data_in,
    output mem_ready
  );

endinterface : arm_wb_if

// File: rtl/arm_wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// Generic in-order FIFO of write-back entries. DEPTH must be a power of two
// (>= 2) so the pointers wrap by natural overflow.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_push      : enqueue i_entry (ignored when full)
//   i_pop       : dequeue head (ignored when empty)
//   i_entry     : entry to enqueue
//   o_count     : number of valid entries
//   o_empty     : no valid entries
//   o_full      : count == DEPTH
//   o_head      : oldest entry (contents meaningless when empty)
//   o_rd_ptr    : slot index of the head entry
//   o_entries   : raw slot array, for forwarding lookups
// -----------------------------------------------------------------------------
module wb_queue
  import arm_wb_pkg::*;
#(
  parameter int  DEPTH   = WB_DEPTH_DEFAULT,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  entry_t                 i_entry,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output entry_t                 o_head,
  output logic [PTR_W-1:0]       o_rd_ptr,
  output entry_t [DEPTH-1:0]     o_entries
);

  entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: non-blocking assignments for every register so all state in this
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; a slot is only
  // ever observed while it lies within [rd_ptr, rd_ptr + count), so stale data
  // after reset is invisible and the array maps onto plain flops/LUT-RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_rd_ptr  = r_rd_ptr;
  assign o_entries = r_mem;

endmodule : wb_queue

// File: rtl/arm_wb_stage.sv
// -----------------------------------------------------------------------------
// arm_wb_stage
// Write-back stage of the ARM pipeline: producing end of the register-file
// write port. Completed MEM-stage instructions are accepted over a
// valid/ready handshake, the ALU/load result is selected at enqueue, and the
// entry is buffered in a small in-order queue that absorbs wb_hold stalls.
// The register file samples writeBackEn/Dest_wb/Result_WB on the falling
// edge; all outputs here change only after rising edges.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   mem_if       : arm_wb_if.slave handshake from the MEM stage
//   wb_hold      : freeze draining (head stays, nothing popped)
//   writeBackEn  : register-file write enable
//   Dest_wb      : register-file write index (0 when empty)
//   Result_WB    : register-file write data (0 when empty)
//   wb_busy      : queue non-empty
// Optional (macro ARM_WB_FWD_EN):
//   fwd_src1/2   : decode-stage source indices to look up
//   fwd_hit1/2   : a queued writing entry targets that register
//   fwd_data1/2  : data of the youngest such entry (0 on miss)
// Without ARM_WB_FWD_EN the forwarding ports do not exist and decode must
// stall on wb_busy.
// -----------------------------------------------------------------------------
module arm_wb_stage
  import arm_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEFAULT,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  arm_wb_if.slave              mem_if,
  input  logic                 wb_hold,
  output logic                 writeBackEn,
  output logic [REG_IDX_W-1:0] Dest_wb,
  output logic [DATA_W-1:0]    Result_WB,
  output logic                 wb_busy
`ifdef ARM_WB_FWD_EN
  ,
  input  logic [REG_IDX_W-1:0] fwd_src1,
  input  logic [REG_IDX_W-1:0] fwd_src2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DATA_W-1:0]    fwd_data1,
  output logic [DATA_W-1:0]    fwd_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Same shape as wb_entry_t, but sized by this instance's DATA_W.
  typedef struct packed {
    logic                 wb_en;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    data;
  } entry_t;

  entry_t               w_in_entry;
  entry_t               w_head;
  entry_t [DEPTH-1:0]   w_entries;
  logic [CNT_W-1:0]     w_count;
  logic [PTR_W-1:0]     w_rd_ptr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  // Result mux resolved at enqueue so the queue holds only final write data.
  assign w_in_entry.wb_en = mem_if.wb_en_in;
  assign w_in_entry.dest  = mem_if.dest_in;
  assign w_in_entry.data  = mem_if.mem_r_en_in ? mem_if.mem_data_in
                                               : mem_if.alu_result_in;

  // Ready is not pop-aware: it depends on registered count only, which keeps
  // the MEM-stage handshake free of a combinational path from wb_hold.
  assign mem_if.mem_ready = !w_full;
  assign w_push           = mem_if.mem_valid && !w_full;
  assign w_pop            = !w_empty && !wb_hold;

  wb_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_entry   (w_in_entry),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_head    (w_head),
    .o_rd_ptr  (w_rd_ptr),
    .o_entries (w_entries)
  );

  // A held head must not write: the register-file port is frozen and the same
  // entry will be presented again once wb_hold falls.
  assign writeBackEn = !w_empty && w_head.wb_en && !wb_hold;
  assign Dest_wb     = w_empty ? '0 : w_head.dest;
  assign Result_WB   = w_empty ? '0 : w_head.data;
  assign wb_busy     = !w_empty;

`ifdef ARM_WB_FWD_EN
  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < w_count) begin
        if (w_entries[w_rd_ptr + PTR_W'(k)].wb_en &&
            w_entries[w_rd_ptr + PTR_W'(k)].dest == fwd_src1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = w_entries[w_rd_ptr + PTR_W'(k)].data;
        end
        if (w_entries[w_rd_ptr + PTR_W'(k)].wb_en &&
            w_entries[w_rd_ptr + PTR_W'(k)].dest == fwd_src2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = w_entries[w_rd_ptr + PTR_W'(k)].data;
        end
      end
    end
  end
`else
  // The entry view only feeds forwarding; tie it off explicitly.
  logic w_unused_fwd_view;
  assign w_unused_fwd_view = ^{w_entries, w_count, w_rd_ptr};
`endif

endmodule : arm_wb_stage

// File: tb/tb_arm_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_arm_wb_stage
// Directed bench for arm_wb_stage. A behavioural register file samples the
// write port on the falling edge, exactly as the real one does.
// Forwarding checks are compiled in when ARM_WB_FWD_EN is defined.
// -----------------------------------------------------------------------------
module tb_arm_wb_stage;
  import arm_wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_hold;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        wb_busy;
`ifdef ARM_WB_FWD_EN
  logic [3:0]  fwd_src1, fwd_src2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  arm_wb_if #(.DATA_W(DATA_W)) mif ();

  arm_wb_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_if      (mif),
    .wb_hold     (wb_hold),
    .writeBackEn (writeBackEn),
    .Dest_wb     (Dest_wb),
    .Result_WB   (Result_WB),
    .wb_busy     (wb_busy)
`ifdef ARM_WB_FWD_EN
    ,
    .fwd_src1    (fwd_src1),
    .fwd_src2    (fwd_src2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Register-file model: writes on the falling edge.
  logic [31:0] rf [16];
  int          n_writes = 0;
  always @(negedge clk) begin
    if (writeBackEn) begin
      rf[Dest_wb] <= Result_WB;
      n_writes    <= n_writes + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mif.mem_valid     = 1'b0;
    mif.wb_en_in      = 1'b0;
    mif.mem_r_en_in   = 1'b0;
    mif.dest_in       = 4'd0;
    mif.alu_result_in = 32'd0;
    mif.mem_data_in   = 32'd0;
  endtask

  task automatic present(input logic we, input logic re, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] md);
    mif.mem_valid     = 1'b1;
    mif.wb_en_in      = we;
    mif.mem_r_en_in   = re;
    mif.dest_in       = d;
    mif.alu_result_in = alu;
    mif.mem_data_in   = md;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    wb_hold = 1'b0;
    idle_inputs();
    step();
    step();
    n_cmp++; if (writeBackEn !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %0b want 0", writeBackEn); end
    n_cmp++; if (Dest_wb !== 4'd0) begin n_bad++; $display("FAIL rst_dest: got %0d want 0", Dest_wb); end
    n_cmp++; if (Result_WB !== 32'd0) begin n_bad++; $display("FAIL rst_result: got %h want 0", Result_WB); end
    n_cmp++; if (mif.mem_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", mif.mem_ready); end
    n_cmp++; if (wb_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", wb_busy); end
    rst = 1'b0;
    step();
    n_cmp++; if (mif.mem_ready !== 1'b1 || wb_busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: ready %0b busy %0b want 1 0", mif.mem_ready, wb_busy); end
  endtask

  task automatic test_alu_write();
    present(1'b1, 1'b0, 4'd3, 32'h0000_1234, 32'h5555_5555);
    step();
    idle_inputs();
    settle();
    n_cmp++; if (writeBackEn !== 1'b1) begin n_bad++; $display("FAIL alu_wen: got %0b want 1", writeBackEn); end
    n_cmp++; if (Dest_wb !== 4'd3) begin n_bad++; $display("FAIL alu_dest: got %0d want 3", Dest_wb); end
    n_cmp++; if (Result_WB !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_result: got %h want 00001234", Result_WB); end
    n_cmp++; if (wb_busy !== 1'b1) begin n_bad++; $display("FAIL alu_busy: got %0b want 1", wb_busy); end
    @(negedge clk); #1;
    n_cmp++; if (rf[3] !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_rf3: got %h want 00001234", rf[3]); end
    step();
    n_cmp++; if (wb_busy !== 1'b0 || writeBackEn !== 1'b0) begin n_bad++; $display("FAIL alu_drained: busy %0b wen %0b want 0 0", wb_busy, writeBackEn); end
  endtask

  task automatic test_load_select();
    present(1'b1, 1'b1, 4'd7, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    settle();
    n_cmp++; if (Result_WB !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_result: got %h want deadbeef", Result_WB); end
    n_cmp++; if (Dest_wb !== 4'd7) begin n_bad++; $display("FAIL load_dest: got %0d want 7", Dest_wb); end
    @(negedge clk); #1;
    n_cmp++; if (rf[7] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_rf7: got %h want deadbeef", rf[7]); end
    step();
  endtask

  task automatic test_hold_full();
    wb_hold = 1'b1;
    present(1'b1, 1'b0, 4'd1, 32'h0000_0111, 32'd0);
    step();
    n_cmp++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd1) begin n_bad++; $display("FAIL hold_first: wen %0b dest %0d want 0 1", writeBackEn, Dest_wb); end
    n_cmp++; if (mif.mem_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready1: got %0b want 1", mif.mem_ready); end
    present(1'b1, 1'b0, 4'd2, 32'h0000_0222, 32'd0);
    step();
    present(1'b1, 1'b0, 4'd3, 32'h0000_0333, 32'd0);
    settle();
    n_cmp++; if (mif.mem_ready !== 1'b0) begin n_bad++; $display("FAIL hold_full_ready: got %0b want 0", mif.mem_ready); end
    step();
    n_cmp++; if (mif.mem_ready !== 1'b0 || Dest_wb !== 4'd1 || writeBackEn !== 1'b0) begin n_bad++; $display("FAIL hold_refused: ready %0b dest %0d wen %0b want 0 1 0", mif.mem_ready, Dest_wb, writeBackEn); end
    wb_hold = 1'b0;
    settle();
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd1 || Result_WB !== 32'h0000_0111) begin n_bad++; $display("FAIL release_r1: wen %0b dest %0d data %h want 1 1 00000111", writeBackEn, Dest_wb, Result_WB); end
    n_cmp++; if (mif.mem_ready !== 1'b0) begin n_bad++; $display("FAIL release_ready0: got %0b want 0", mif.mem_ready); end
    @(negedge clk); #1;
    n_cmp++; if (rf[1] !== 32'h0000_0111) begin n_bad++; $display("FAIL release_rf1: got %h want 00000111", rf[1]); end
    step();
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd2 || mif.mem_ready !== 1'b1) begin n_bad++; $display("FAIL release_r2: wen %0b dest %0d ready %0b want 1 2 1", writeBackEn, Dest_wb, mif.mem_ready); end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (Dest_wb !== 4'd3 || Result_WB !== 32'h0000_0333 || wb_busy !== 1'b1) begin n_bad++; $display("FAIL accept_r3: dest %0d data %h busy %0b want 3 00000333 1", Dest_wb, Result_WB, wb_busy); end
    n_cmp++; if (rf[2] !== 32'h0000_0222) begin n_bad++; $display("FAIL release_rf2: got %h want 00000222", rf[2]); end
    step();
    n_cmp++; if (wb_busy !== 1'b0 || rf[3] !== 32'h0000_0333) begin n_bad++; $display("FAIL drain_r3: busy %0b rf3 %h want 0 00000333", wb_busy, rf[3]); end
  endtask

  task automatic test_no_write();
    present(1'b0, 1'b0, 4'd5, 32'h0000_0055, 32'd0);
    step();
    present(1'b1, 1'b0, 4'd6, 32'h0000_0066, 32'd0);
    settle();
    n_cmp++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd5) begin n_bad++; $display("FAIL nowrite_slot: wen %0b dest %0d want 0 5", writeBackEn, Dest_wb); end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd6 || Result_WB !== 32'h0000_0066) begin n_bad++; $display("FAIL nowrite_next: wen %0b dest %0d data %h want 1 6 00000066", writeBackEn, Dest_wb, Result_WB); end
    @(negedge clk); #1;
    n_cmp++; if (rf[5] !== 32'hF000_0005) begin n_bad++; $display("FAIL nowrite_rf5: got %h want f0000005", rf[5]); end
    n_cmp++; if (rf[6] !== 32'h0000_0066) begin n_bad++; $display("FAIL nowrite_rf6: got %h want 00000066", rf[6]); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      present(1'b1, 1'b0, 4'(8 + i), 32'h0000_0800 + 32'(i), 32'd0);
      step();
      n_cmp++; if (mif.mem_ready !== 1'b1 || writeBackEn !== 1'b1 || Dest_wb !== 4'(8 + i)) begin n_bad++; $display("FAIL b2b_%0d: ready %0b wen %0b dest %0d want 1 1 %0d", i, mif.mem_ready, writeBackEn, Dest_wb, 8 + i); end
    end
    idle_inputs();
    step();
    n_cmp++; if (wb_busy !== 1'b0 || rf[9] !== 32'h0000_0801 || rf[11] !== 32'h0000_0803) begin n_bad++; $display("FAIL b2b_rf: busy %0b rf9 %h rf11 %h want 0 00000801 00000803", wb_busy, rf[9], rf[11]); end
  endtask

`ifdef ARM_WB_FWD_EN
  task automatic test_forwarding();
    wb_hold = 1'b1;
    present(1'b1, 1'b0, 4'd4, 32'h0000_000A, 32'd0);
    step();
    present(1'b1, 1'b0, 4'd4, 32'h0000_000B, 32'd0);
    step();
    idle_inputs();
    fwd_src1 = 4'd4;
    fwd_src2 = 4'd9;
    settle();
    n_cmp++; if (fwd_hit1 !== 1'b1) begin n_bad++; $display("FAIL fwd_hit1: got %0b want 1", fwd_hit1); end
    n_cmp++; if (fwd_data1 !== 32'h0000_000B) begin n_bad++; $display("FAIL fwd_data1: got %h want 0000000b", fwd_data1); end
    n_cmp++; if (fwd_hit2 !== 1'b0) begin n_bad++; $display("FAIL fwd_hit2: got %0b want 0", fwd_hit2); end
    wb_hold = 1'b0;
    step();
    step();
    n_cmp++; if (fwd_hit1 !== 1'b0 || wb_busy !== 1'b0 || rf[4] !== 32'h0000_000B) begin n_bad++; $display("FAIL fwd_drain: hit1 %0b busy %0b rf4 %h want 0 0 0000000b", fwd_hit1, wb_busy, rf[4]); end
  endtask
`endif

  task automatic test_reset_mid_traffic();
    int writes_before;
    wb_hold = 1'b1;
    present(1'b1, 1'b0, 4'd12, 32'h0000_AAAA, 32'd0);
    step();
    present(1'b1, 1'b0, 4'd13, 32'h0000_BBBB, 32'd0);
    step();
    idle_inputs();
    settle();
    n_cmp++; if (wb_busy !== 1'b1 || mif.mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_prefill: busy %0b ready %0b want 1 0", wb_busy, mif.mem_ready); end
    writes_before = n_writes;
    rst = 1'b1;
    settle();
    n_cmp++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd0 || Result_WB !== 32'd0) begin n_bad++; $display("FAIL mid_rst_out: wen %0b dest %0d data %h want 0 0 0", writeBackEn, Dest_wb, Result_WB); end
    n_cmp++; if (mif.mem_ready !== 1'b1 || wb_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: ready %0b busy %0b want 1 0", mif.mem_ready, wb_busy); end
    step();
    rst     = 1'b0;
    wb_hold = 1'b0;
    step();
    step();
    n_cmp++; if (wb_busy !== 1'b0 || writeBackEn !== 1'b0) begin n_bad++; $display("FAIL mid_after: busy %0b wen %0b want 0 0", wb_busy, writeBackEn); end
    n_cmp++; if (n_writes !== writes_before || rf[12] !== 32'hF000_000C || rf[13] !== 32'hF000_000D) begin n_bad++; $display("FAIL mid_no_write: writes %0d rf12 %h rf13 %h want %0d f000000c f000000d", n_writes, rf[12], rf[13], writes_before); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hF000_0000 | 32'(i);
`ifdef ARM_WB_FWD_EN
    fwd_src1 = 4'd0;
    fwd_src2 = 4'd0;
`endif
    test_reset();
    test_alu_write();
    test_load_select();
    test_no_write();
    test_hold_full();
    test_back_to_back();
`ifdef ARM_WB_FWD_EN
    test_forwarding();
`endif
    test_reset_mid_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_arm_wb_stage
